// File: rtl/multadd_pkg.sv
// Shared widths, saturation limits and the round/shift/saturate helper for the
// integrate-and-dump stage that follows the multiply-add.
package multadd_pkg;

    localparam int IN_W      = 48;
    localparam int LEN_W     = 8;
    localparam int ACC_W     = IN_W + LEN_W;
    localparam int OUT_W     = 16;
    localparam int SHIFT_W   = 6;
    localparam int MAX_SHIFT = 40;

    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef struct packed {
        logic                    sat;
        logic signed [OUT_W-1:0] data;
    } result_t;

    localparam int RES_W = $bits(result_t);

    // Round half toward +inf, arithmetic shift, then clamp to the output range.
    // One guard bit keeps the rounding bias from wrapping a near-full sum.
    function automatic result_t round_sat(input logic signed [ACC_W-1:0] sum,
                                          input logic [SHIFT_W-1:0]      sh);
        logic signed [ACC_W:0] bias;
        logic signed [ACC_W:0] r;
        result_t               res;
        bias = (sh == '0) ? '0 : ((ACC_W+1)'(1) << (sh - SHIFT_W'(1)));
        r    = {sum[ACC_W-1], sum} + bias;
        r    = r >>> sh;
        if (r > (ACC_W+1)'(OUT_MAX)) begin
            res.sat  = 1'b1;
            res.data = OUT_MAX;
        end else if (r < (ACC_W+1)'(OUT_MIN)) begin
            res.sat  = 1'b1;
            res.data = OUT_MIN;
        end else begin
            res.sat  = 1'b0;
            res.data = r[OUT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/multadd_acc_dump_if.sv
// Sample input and result output handshakes of the integrate-and-dump block.
interface multadd_acc_dump_if;
    import multadd_pkg::*;

    logic               in_valid;
    logic [IN_W-1:0]    in_p;
    logic               in_ready;
    logic [LEN_W-1:0]   len;
    logic [SHIFT_W-1:0] shift;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;
    logic               out_sat;

    modport master (
        output in_valid, in_p, len, shift, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_p, len, shift, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

endinterface

// File: rtl/sync_fifo3.sv
// Three-entry synchronous FIFO with occupancy output; the head reads as zero
// whenever the FIFO is empty.
module sync_fifo3 #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sclr,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [3];
    logic [1:0]   wr_ptr_q, rd_ptr_q, count_q;
    logic [1:0]   count_d;
    logic         do_push, do_pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign do_push = push_i && (count_q != 2'd3);
    assign do_pop  = pop_i  && (count_q != 2'd0);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (sclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_d;
        end
    end

    // NOTE: storage has no reset; the count alone decides validity and the head is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/multadd_acc_dump.sv
// Integrate-and-dump of the multiply-add P stream: accumulate len samples, then
// round/shift/saturate to 16 bits and queue the result in a 3-entry FIFO.
module multadd_acc_dump
    import multadd_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sclr,
    multadd_acc_dump_if.slave   bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACC  = 1'b1;

    logic [0:0]              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [SHIFT_W-1:0]      shift_q, shift_d;
    logic signed [ACC_W-1:0] s1_sum_q, s1_sum_d;
    logic [SHIFT_W-1:0]      s1_shift_q, s1_shift_d;
    logic                    s1_valid_q, s1_valid_d;

    logic                    accept;
    logic signed [ACC_W-1:0] sample, sum;
    logic [LEN_W-1:0]        len_eff, cnt_inc;
    logic [SHIFT_W-1:0]      shift_eff;
    result_t                 s2_res, head;
    logic [1:0]              fifo_count;

    assign accept    = bus.in_valid && bus.in_ready;
    assign sample    = {{(ACC_W-IN_W){bus.in_p[IN_W-1]}}, bus.in_p};
    assign sum       = acc_q + sample;
    assign cnt_inc   = cnt_q + LEN_W'(1);
    assign len_eff   = (bus.len == '0) ? LEN_W'(1) : bus.len;
    assign shift_eff = (bus.shift > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : bus.shift;

    // NOTE: combinational next-state uses blocking '=' with every target defaulted first, so no latches form.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        shift_d    = shift_q;
        s1_sum_d   = s1_sum_q;
        s1_shift_d = s1_shift_q;
        s1_valid_d = 1'b0;
        if (accept) begin
            if (state_q == IDLE) begin
                len_d   = len_eff;
                shift_d = shift_eff;
                if (len_eff == LEN_W'(1)) begin
                    s1_valid_d = 1'b1;
                    s1_sum_d   = sample;
                    s1_shift_d = shift_eff;
                end else begin
                    acc_d   = sample;
                    cnt_d   = LEN_W'(1);
                    state_d = ACC;
                end
            end else if (cnt_inc == len_q) begin
                // Final sum leaves for stage 1; the accumulator is free next cycle.
                s1_valid_d = 1'b1;
                s1_sum_d   = sum;
                s1_shift_d = shift_q;
                cnt_d      = '0;
                state_d    = IDLE;
            end else begin
                acc_d = sum;
                cnt_d = cnt_inc;
            end
        end
    end

    // NOTE: registered state is written only with non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            shift_q    <= '0;
            s1_sum_q   <= '0;
            s1_shift_q <= '0;
            s1_valid_q <= 1'b0;
        end else if (sclr) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            shift_q    <= '0;
            s1_sum_q   <= '0;
            s1_shift_q <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            s1_sum_q   <= s1_sum_d;
            s1_shift_q <= s1_shift_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    assign s2_res = round_sat(s1_sum_q, s1_shift_q);

    // in_ready counts the stage-1 result as occupied space, so the push never finds the FIFO full.
    sync_fifo3 #(.W(RES_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .sclr    (sclr),
        .push_i  (s1_valid_q),
        .wdata_i (s2_res),
        .pop_i   (bus.out_valid && bus.out_ready),
        .rdata_o (head),
        .count_o (fifo_count)
    );

    assign bus.in_ready  = (3'(fifo_count) + 3'(s1_valid_q)) <= 3'd2;
    assign bus.out_valid = (fifo_count != 2'd0);
    assign bus.out_data  = head.data;
    assign bus.out_sat   = head.sat;

endmodule
